// File: rtl/spi_regslave_pkg.sv
// Shared constants, fetch FSM encoding and address-width helper
// for the SPI register slave.
package spi_regslave_pkg;

    localparam int CS_SYNC_DEPTH   = 3;
    localparam int SCK_SYNC_DEPTH  = 3;
    localparam int MOSI_SYNC_DEPTH = 2;

    typedef enum logic [1:0] {
        F_IDLE = 2'd0,
        F_WAIT = 2'd1,
        F_LOAD = 2'd2
    } fetch_e;

    function automatic int addr_width(input int nreg);
        return (nreg > 1) ? $clog2(nreg) : 1;
    endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Parametrised-depth synchroniser for one SPI pin with rise/fall detect
// taken from stages [DEPTH-1:1].
module spi_edge_sync #(
    parameter int DEPTH = 3
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic lvl_o,
    output logic rise_o,
    output logic fall_o
);

    logic [DEPTH-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[DEPTH-2:0], d_i};
        end
    end

    assign lvl_o  = sync_q[1];
    assign rise_o = sync_q[1] & ~sync_q[DEPTH-1];
    assign fall_o = ~sync_q[1] & sync_q[DEPTH-1];

endmodule

// File: rtl/spi_regslave.sv
// SPI register slave: address shifted in with CS high, DW-bit words with CS low.
// Define SPI_REGSLAVE_AUTOINC_EN to advance the address after every word.
module spi_regslave
    import spi_regslave_pkg::*;
#(
    parameter int DW   = 8,
    parameter int NREG = 256,
    localparam int AW  = addr_width(NREG)
) (
    input  logic          fclk,
    input  logic          rst_n,
    input  logic          spics_n,
    input  logic          spick,
    input  logic          spido,
    output logic          spidi,
    input  logic [DW-1:0] status_in,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic          wr_stb,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic          end_stb,
    output logic [AW-1:0] end_addr,
    output logic          end_partial
);

    localparam int          BW   = $clog2(DW);
    localparam logic [BW-1:0] LAST = BW'(DW - 1);

    logic cs_lvl, cs_rise, cs_fall;
    logic sck_rise, sck_lvl_unused, sck_fall_unused;
    logic sdo, sdo_rise_unused, sdo_fall_unused;

    spi_edge_sync #(.DEPTH(CS_SYNC_DEPTH)) u_cs (
        .clk_i  (fclk),
        .rst_ni (rst_n),
        .d_i    (spics_n),
        .lvl_o  (cs_lvl),
        .rise_o (cs_rise),
        .fall_o (cs_fall)
    );

    spi_edge_sync #(.DEPTH(SCK_SYNC_DEPTH)) u_sck (
        .clk_i  (fclk),
        .rst_ni (rst_n),
        .d_i    (spick),
        .lvl_o  (sck_lvl_unused),
        .rise_o (sck_rise),
        .fall_o (sck_fall_unused)
    );

    spi_edge_sync #(.DEPTH(MOSI_SYNC_DEPTH)) u_sdo (
        .clk_i  (fclk),
        .rst_ni (rst_n),
        .d_i    (spido),
        .lvl_o  (sdo),
        .rise_o (sdo_rise_unused),
        .fall_o (sdo_fall_unused)
    );

    logic [DW-1:0] shout_q, shout_d;
    logic [AW-1:0] regnum_q, regnum_d;
    logic [BW-1:0] bitcnt_q, bitcnt_d;
    logic [DW-2:0] rxsh_q, rxsh_d;
    logic [AW-1:0] addr_q, addr_d, addr_nxt;
    logic [AW-1:0] start_q, start_d;
    logic          in_data_q, in_data_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [DW-1:0] wr_data_q, wr_data_d;
    logic          done_q, done_d;
    logic          wr_stb_q;
    logic          end_stb_q, end_stb_d;
    logic [AW-1:0] end_addr_q, end_addr_d;
    logic          end_part_q, end_part_d;
    fetch_e        fst_q, fst_d;
    logic          sched;

`ifdef SPI_REGSLAVE_AUTOINC_EN
    assign addr_nxt = (addr_q == AW'(NREG - 1)) ? '0 : addr_q + 1'b1;
`else
    assign addr_nxt = addr_q;
`endif

    always_comb begin
        shout_d    = shout_q;
        regnum_d   = regnum_q;
        bitcnt_d   = bitcnt_q;
        rxsh_d     = rxsh_q;
        addr_d     = addr_q;
        start_d    = start_q;
        in_data_d  = in_data_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        done_d     = 1'b0;
        end_stb_d  = 1'b0;
        end_addr_d = end_addr_q;
        end_part_d = 1'b0;
        fst_d      = fst_q;
        sched      = 1'b0;

        // CS edges take priority; an SCK edge in the same cycle is dropped
        if (cs_rise) begin
            shout_d   = status_in;
            regnum_d  = '0;
            bitcnt_d  = '0;
            in_data_d = 1'b0;
            if (in_data_q) begin
                end_stb_d  = 1'b1;
                end_addr_d = start_q;
                end_part_d = (bitcnt_q != '0);
            end
        end else if (cs_fall) begin
            addr_d    = regnum_q;
            start_d   = regnum_q;
            bitcnt_d  = '0;
            in_data_d = 1'b1;
            sched     = 1'b1;
        end else if (sck_rise) begin
            shout_d = {1'b0, shout_q[DW-1:1]};
            if (cs_lvl) begin
                regnum_d = AW'({sdo, regnum_q} >> 1);
            end else if (in_data_q) begin
                if (bitcnt_q == LAST) begin
                    wr_data_d = {sdo, rxsh_q};
                    wr_addr_d = addr_q;
                    done_d    = 1'b1;
                    bitcnt_d  = '0;
                    addr_d    = addr_nxt;
                    sched     = 1'b1;
                end else begin
                    rxsh_d   = {sdo, rxsh_q[DW-2:1]};
                    bitcnt_d = bitcnt_q + 1'b1;
                end
            end
        end

        if (!cs_rise) begin
            unique case (fst_q)
                F_WAIT: fst_d = F_LOAD;
                F_LOAD: begin
                    shout_d = rd_data;
                    fst_d   = F_IDLE;
                end
                default: fst_d = F_IDLE;
            endcase
            if (sched) fst_d = F_WAIT;
        end
    end

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            shout_q    <= '0;
            regnum_q   <= '0;
            bitcnt_q   <= '0;
            rxsh_q     <= '0;
            addr_q     <= '0;
            start_q    <= '0;
            in_data_q  <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            done_q     <= 1'b0;
            wr_stb_q   <= 1'b0;
            end_stb_q  <= 1'b0;
            end_addr_q <= '0;
            end_part_q <= 1'b0;
            fst_q      <= F_IDLE;
        end else begin
            shout_q    <= shout_d;
            regnum_q   <= regnum_d;
            bitcnt_q   <= bitcnt_d;
            rxsh_q     <= rxsh_d;
            addr_q     <= addr_d;
            start_q    <= start_d;
            in_data_q  <= in_data_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            done_q     <= done_d;
            wr_stb_q   <= done_q;
            end_stb_q  <= end_stb_d;
            end_addr_q <= end_addr_d;
            end_part_q <= end_part_d;
            fst_q      <= fst_d;
        end
    end

    assign spidi       = shout_q[0];
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign wr_stb      = wr_stb_q;
    assign rd_addr     = addr_q;
    assign end_stb     = end_stb_q;
    assign end_addr    = end_addr_q;
    assign end_partial = end_part_q;

endmodule
